// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: IF/ID and PC sequencing for load-use, branch flush and MDU occupancy.
// Optional HAZARD_STALL_CNT_EN adds a wrapping count of cycles with wir=0.
module pipeline_hazard_ctrl #(
  parameter int MDU_LAT = 32,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic        ex_wreg,
  input  logic        ex_m2reg,
  input  logic [4:0]  ex_rn,
  input  logic        id_branch_tk,
  input  logic        id_mdu_start,
  output logic        wpc,
  output logic        wir,
  output logic        if_flush,
  output logic        id_bubble,
  output logic        mdu_busy,
  output logic [31:0] stall_count
);
  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             lu, stall, start;
  assign lu = ex_wreg & ex_m2reg & (ex_rn != 5'd0) &
              ((id_use_rs & (id_rs == ex_rn)) | (id_use_rt & (id_rt == ex_rn)));
  // While clrn is low the pipeline is released, so every stall term is gated by clrn.
  assign mdu_busy  = state == BUSY;
  assign stall     = clrn & (mdu_busy | lu);
  assign start     = clrn & ~stall & id_mdu_start;
  assign wpc       = ~stall;
  assign wir       = ~stall;
  assign id_bubble = stall;
  assign if_flush  = clrn & ~stall & id_branch_tk;
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state <= RUN;
      cnt   <= '0;
    end else if (mdu_busy) begin
      cnt   <= (cnt == '0) ? '0 : cnt - 1'b1;
      state <= (cnt == '0) ? RUN : BUSY;
    end else if (start) begin
      state <= BUSY;
      cnt   <= CNT_W'(MDU_LAT - 2);
    end
  end
`ifdef HAZARD_STALL_CNT_EN
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) stall_count <= '0;
    else if (!wir) stall_count <= stall_count + 32'd1;
  end
`else
  assign stall_count = 32'd0;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: scoreboarded directed + random check of pipeline_hazard_ctrl (MDU_LAT=4).
module tb_pipeline_hazard_ctrl;
  localparam int MDU_LAT = 4;
`ifdef HAZARD_STALL_CNT_EN
  localparam bit SC_EN = 1'b1;
`else
  localparam bit SC_EN = 1'b0;
`endif
  logic clk = 1'b0, clrn = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, ex_rn = '0;
  logic id_use_rs = 0, id_use_rt = 0, ex_wreg = 0, ex_m2reg = 0, id_branch_tk = 0, id_mdu_start = 0;
  logic wpc, wir, if_flush, id_bubble, mdu_busy;
  logic [31:0] stall_count;
  typedef struct {logic wpc, wir, fl, bub, mb; logic [31:0] sc;} exp_t;
  exp_t q[$];
  int tests = 0, failed = 0;
  int freeze = 0;
  int unsigned sc = 0;

  pipeline_hazard_ctrl #(.MDU_LAT(MDU_LAT), .CNT_W(8)) dut (
    .clk(clk), .clrn(clrn), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_rn(ex_rn),
    .id_branch_tk(id_branch_tk), .id_mdu_start(id_mdu_start), .wpc(wpc), .wir(wir),
    .if_flush(if_flush), .id_bubble(id_bubble), .mdu_busy(mdu_busy), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      failed++;
      $display("FAIL %s at %0t: got %0h expected %0h", n, $time, act, exp_v);
    end
  endtask

  // Model: freeze = frozen cycles still owed to the MDU; sc = stalled cycles so far.
  task automatic cyc(input logic c, input logic [4:0] rs, input logic [4:0] rt,
                     input logic urs, input logic urt, input logic wr, input logic m2,
                     input logic [4:0] rn, input logic br, input logic st);
    exp_t e;
    bit busy, lu, stl;
    clrn = c; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    ex_wreg = wr; ex_m2reg = m2; ex_rn = rn; id_branch_tk = br; id_mdu_start = st;
    if (!c) begin
      e = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0};
      freeze = 0;
      sc = 0;
    end else begin
      busy = freeze > 0;
      lu = wr && m2 && rn != 0 && ((urs && rs == rn) || (urt && rt == rn));
      stl = busy || lu;
      e = '{!stl, !stl, !stl && br, stl, busy, SC_EN ? sc : 32'd0};
      if (busy) freeze--;
      else if (!lu && st) freeze = MDU_LAT - 1;
      if (stl) sc++;
    end
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("wpc", 32'(wpc), 32'(e.wpc));
      chk("wir", 32'(wir), 32'(e.wir));
      chk("if_flush", 32'(if_flush), 32'(e.fl));
      chk("id_bubble", 32'(id_bubble), 32'(e.bub));
      chk("mdu_busy", 32'(mdu_busy), 32'(e.mb));
      chk("stall_count", stall_count, e.sc);
    end
  end

  initial begin
    @(posedge clk);
    #1;
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 5, 0, 1, 0, 1, 1, 5, 1, 1);
    cyc(1, 5, 0, 1, 0, 1, 1, 5, 0, 0);
    cyc(1, 5, 0, 1, 0, 0, 0, 5, 0, 0);
    cyc(1, 0, 0, 1, 0, 1, 1, 0, 0, 0);
    cyc(1, 3, 7, 0, 1, 1, 1, 7, 0, 0);
    cyc(1, 3, 7, 0, 1, 1, 1, 7, 1, 0);
    cyc(1, 3, 7, 0, 1, 0, 0, 7, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    repeat (4) idle();
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) idle();
    cyc(1, 4, 4, 1, 1, 1, 1, 4, 0, 1);
    cyc(1, 4, 4, 1, 1, 0, 1, 4, 0, 1);
    repeat (4) idle();
    for (int i = 0; i < 600; i++) begin
      logic c;
      c = $urandom_range(0, 39) != 0;
      cyc(c, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
          1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
          $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
    end
    @(negedge clk);
    #1;
    tests++;
    if (q.size() != 0) begin
      failed++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
